// File: rtl/vec_issue_seq_if.sv
// Purpose : control/handshake bundle between the vector issue sequencer and
//           the instruction decode / element datapath around it.
// Ports   : start, vlen, ack, alu_flags flow into the sequencer. busy, stall,
//           elem_valid, elem_idx, vrf_we, done, err, flags_acc flow out of it.
//           The master modport is the sequencer; the slave modport is the
//           decoder/ALU side that drives the request and element ack.
interface vec_issue_seq_if #(
    parameter int IDX_W  = 4,
    parameter int FLAG_W = 4
);
    // decode / element path -> sequencer
    logic              start;
    logic [IDX_W-1:0]  vlen;
    logic              ack;
    logic [FLAG_W-1:0] alu_flags;

    // sequencer -> PC, VRF, ALU, condition logic
    logic              busy;
    logic              stall;
    logic              elem_valid;
    logic [IDX_W-1:0]  elem_idx;
    logic              vrf_we;
    logic              done;
    logic              err;
    logic [FLAG_W-1:0] flags_acc;

    modport master (
        input  start, vlen, ack, alu_flags,
        output busy, stall, elem_valid, elem_idx, vrf_we, done, err, flags_acc
    );

    modport slave (
        output start, vlen, ack, alu_flags,
        input  busy, stall, elem_valid, elem_idx, vrf_we, done, err, flags_acc
    );
endinterface

// File: rtl/vec_issue_seq.sv
// Purpose     : splits one vector instruction of length vlen into per-element
//               issues on the shared ALU/VALU path, writes one VRF lane per element
//               and folds the element flags into one {N,Z,C,V} result.
// Latency     : element k issued in cycle 1+2k, written in cycle 2+2k, done in
//               cycle 2*vlen+1 after the accepting cycle (ack tied high).
// Backpressure: an element waits in ISSUE for ack with no timeout; stall
//               holds the PC from the accepting cycle through DONE.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   bus.start    vector instruction present (only looked at while IDLE)
//   bus.vlen     element count, sampled with start; 0 completes at once,
//                above MAX_LEN is rejected with a one-cycle err pulse
//   bus.ack      element path has taken the current element this cycle
//   bus.alu_flags {N,Z,C,V} of the element being acked
//   bus.busy / stall / elem_valid / elem_idx / vrf_we / done / err / flags_acc
module vec_issue_seq #(
    parameter int MAX_LEN = 10,
    parameter int IDX_W   = 4,
    parameter int FLAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    vec_issue_seq_if.master   bus
);

    // FSM encoding kept as plain constants so older netlists/probes that
    // look at the raw state value still line up.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Flag bit positions inside {N,Z,C,V}
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Z starts set so an all-zero vector reports Z; N/C/V start clear.
    localparam logic [FLAG_W-1:0] FLAGS_INIT = FLAG_W'(4'b0100);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_LEN);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  len;
    logic [FLAG_W-1:0] elem_flags;   // flags of the element just acked
    logic [FLAG_W-1:0] flags_acc_q;
    logic              err_q;

    logic              in_idle;
    logic              vlen_zero;
    logic              vlen_over;
    logic              last_elem;
    logic [FLAG_W-1:0] flags_next;

    assign in_idle   = (state == ST_IDLE);
    assign vlen_zero = (bus.vlen == '0);
    assign vlen_over = (bus.vlen > LEN_MAX);
    // len is at least 1 whenever we are in WB, so len-1 never underflows here
    assign last_elem = (idx == (len - IDX_ONE));

    // Flag fold across elements: N follows the last element, Z survives only
    // if every element was zero, C and V are sticky.
    always_comb begin
        flags_next        = flags_acc_q;
        flags_next[N_BIT] = elem_flags[N_BIT];
        flags_next[Z_BIT] = flags_acc_q[Z_BIT] & elem_flags[Z_BIT];
        flags_next[C_BIT] = flags_acc_q[C_BIT] | elem_flags[C_BIT];
        flags_next[V_BIT] = flags_acc_q[V_BIT] | elem_flags[V_BIT];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            len         <= '0;
            elem_flags  <= '0;
            flags_acc_q <= FLAGS_INIT;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (vlen_over) begin
                            // Rejected: no state change, flags untouched.
                            err_q <= 1'b1;
                        end else if (vlen_zero) begin
                            idx         <= '0;
                            len         <= '0;
                            flags_acc_q <= FLAGS_INIT;
                            state       <= ST_DONE;
                        end else begin
                            idx         <= '0;
                            len         <= bus.vlen;
                            flags_acc_q <= FLAGS_INIT;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Hold the element (and its index) until the path takes it.
                    if (bus.ack) begin
                        elem_flags <= bus.alu_flags;
                        state      <= ST_WB;
                    end
                end

                ST_WB: begin
                    flags_acc_q <= flags_next;
                    if (last_elem) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= ST_ISSUE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = !in_idle;
    // Raised combinationally in the accepting cycle so the PC does not step
    // past the vector instruction on that edge; covers vlen==0 too, since
    // that op still spends a cycle in DONE.
    assign bus.stall      = !in_idle || (bus.start && !vlen_over);
    assign bus.elem_valid = (state == ST_ISSUE);
    assign bus.vrf_we     = (state == ST_WB);
    assign bus.elem_idx   = idx;
    assign bus.done       = (state == ST_DONE);
    assign bus.err        = err_q;
    assign bus.flags_acc  = flags_acc_q;

endmodule
